// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM encoding and request classification for the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_e;

  // Illegal encodings take priority over misalignment.
  function automatic logic [1:0] classify_request(input logic rd, input logic wr,
                                                  input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    logic misalign;
    illegal  = (rd == wr)
            || (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            || (wr && (f3 >= 3'b011));
    misalign = ((f3[1:0] == 2'b01) && off[0])
            || ((f3[1:0] == 2'b10) && (off != 2'b00));
    if (illegal) return ERR_ILLEGAL;
    if (misalign) return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  byte_off_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_word_i,
  output logic [31:0] store_lanes_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Narrow stores replicate the datum so every lane carries it; enables pick the lane.
  always_comb begin
    store_lanes_o = store_data_i;
    byte_en_o     = 4'b1111;
    if (is_store_i) begin
      case (func3_i[1:0])
        2'b00: begin
          store_lanes_o = {4{store_data_i[7:0]}};
          byte_en_o     = 4'b0001 << byte_off_i;
        end
        2'b01: begin
          store_lanes_o = {2{store_data_i[15:0]}};
          byte_en_o     = byte_off_i[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  assign ld_byte = read_word_i[{byte_off_i, 3'b000} +: 8];
  assign ld_half = byte_off_i[1] ? read_word_i[31:16] : read_word_i[15:0];

  always_comb begin
    case (func3_i)
      F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data_o = {24'b0, ld_byte};
      F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data_o = {16'b0, ld_half};
      default: load_data_o = read_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures an execute-stage access, runs the memory handshake and
// stalls the core until completion, reporting misaligned/illegal/timeout errors.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Start,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_Func3,
  input  logic [31:0]       i_Address,
  input  logic [31:0]       i_WriteData,
  output logic              o_Stall,
  output logic              o_Done,
  output logic [31:0]       o_LoadData,
  output logic              o_Error,
  output logic [1:0]        o_ErrCause,
  output logic              o_Mem_Req,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [31:0]       o_Mem_WData,
  output logic [3:0]        o_Mem_ByteEn,
  input  logic              i_Mem_Ready,
  input  logic              i_Mem_RValid,
  input  logic [31:0]       i_Mem_RData
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        func3_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [1:0]        err_q;
  logic [31:0]       load_q;
  logic [CNT_W-1:0]  tcnt_q;

  logic [1:0]  req_err;
  logic        timeout_hit;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ldata;
  logic [3:0]  lane_be;
  logic        unused_addr_hi;

  assign req_err        = classify_request(i_MemRead, i_MemWrite, i_Func3, i_Address[1:0]);
  // Fires on the last allowed cycle so the abort lands exactly TIMEOUT cycles after entering REQ.
  assign timeout_hit    = (tcnt_q == CNT_W'(TIMEOUT - 1));
  assign unused_addr_hi = ^i_Address[31:ADDR_W+2];

  lsu_lane_align u_align (
    .func3_i       (func3_q),
    .byte_off_i    (addr_q[1:0]),
    .is_store_i    (we_q),
    .store_data_i  (wdata_q),
    .read_word_i   (i_Mem_RData),
    .store_lanes_o (lane_wdata),
    .byte_en_o     (lane_be),
    .load_data_o   (lane_ldata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_Start) state_d = (req_err != ERR_NONE) ? S_DONE : S_REQ;
      S_REQ:    if (i_Mem_Ready) state_d = we_q ? S_DONE : S_WAIT_R;
                else if (timeout_hit) state_d = S_DONE;
      S_WAIT_R: if (i_Mem_RValid || timeout_hit) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Stall      = !reset && ((state_q == S_IDLE && i_Start) || state_q == S_REQ || state_q == S_WAIT_R);
    o_Done       = (state_q == S_DONE);
    o_Error      = o_Done && (err_q != ERR_NONE);
    o_ErrCause   = o_Done ? err_q : ERR_NONE;
    o_Mem_Req    = (state_q == S_REQ);
    o_Mem_We     = 1'b0;
    o_Mem_Addr   = '0;
    o_Mem_WData  = '0;
    o_Mem_ByteEn = '0;
    if (o_Mem_Req) begin
      o_Mem_We     = we_q;
      o_Mem_Addr   = addr_q[ADDR_W+1:2];
      o_Mem_WData  = lane_wdata;
      o_Mem_ByteEn = lane_be;
    end
  end

  assign o_LoadData = load_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= ERR_NONE;
      load_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_Start) begin
          addr_q  <= i_Address[ADDR_W+1:0];
          func3_q <= i_Func3;
          wdata_q <= i_WriteData;
          we_q    <= i_MemWrite;
          err_q   <= req_err;
          tcnt_q  <= '0;
          if (req_err != ERR_NONE) load_q <= '0;
        end
        S_REQ: begin
          tcnt_q <= tcnt_q + CNT_W'(1);
          if (!i_Mem_Ready && timeout_hit) begin
            err_q  <= ERR_TIMEOUT;
            load_q <= '0;
          end
        end
        S_WAIT_R: begin
          tcnt_q <= tcnt_q + CNT_W'(1);
          if (i_Mem_RValid) begin
            load_q <= lane_ldata;
          end else if (timeout_hit) begin
            err_q  <= ERR_TIMEOUT;
            load_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address, rs2 data, funct3, MemRead/MemWrite) and a word-organised synchronous data memory.
- Adds byte and halfword load/store with byte enables, lane steering and sign/zero extension.
- Uses a req/ready/rvalid handshake on the memory side and stalls the core until each access completes.
- Detects misaligned accesses, illegal funct3 values and memory timeouts.

Parameters:
- ADDR_W, 5, word-address width driven to memory (32-word data memory).
- TIMEOUT, 15, maximum cycles spent in REQ+WAIT_R before abort; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_Start  in  1  access request from core, sampled in IDLE only
- i_MemRead  in  1  load request
- i_MemWrite  in  1  store request
- i_Func3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_Address  in  32  byte address from ALU
- i_WriteData  in  32  rs2 value for stores
- o_Stall  out  1  hold PC/pipeline
- o_Done  out  1  one-cycle completion pulse
- o_LoadData  out  32  extended load result, valid when o_Done and no error
- o_Error  out  1  completion carried an error (valid with o_Done)
- o_ErrCause  out  2  01 misaligned, 10 illegal, 11 timeout
- o_Mem_Req  out  1  memory request
- o_Mem_We  out  1  1=write, 0=read
- o_Mem_Addr  out  ADDR_W  word address = i_Address[ADDR_W+1:2]
- o_Mem_WData  out  32  lane-steered store data
- o_Mem_ByteEn  out  4  byte enables
- i_Mem_Ready  in  1  memory accepts request this cycle
- i_Mem_RValid  in  1  read data valid
- i_Mem_RData  in  32  read data word

Behaviour:
- Reset (asynchronous, active-high; clock clk): state IDLE; all outputs 0; timeout counter 0; captured request cleared. Reset mid-access drops the request immediately (o_Mem_Req falls asynchronously).
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, i_Start=1:
  - Capture address, funct3, write data and read/write on the clock edge.
  - o_Stall=1 combinationally in that same cycle.
  - Check the request; the first matching rule in this order applies.
  - Illegal: both MemRead and MemWrite set, neither set, load funct3 in {011,110,111}, or store funct3 ≥ 011 → DONE with cause 10.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0 → DONE with cause 01.
  - Otherwise → REQ.
  - Errored accesses never assert o_Mem_Req.
- REQ:
  - o_Mem_Req=1; address, we, wdata and byte enables stay stable until i_Mem_Ready.
  - On ready, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R: o_Mem_Req=0; on i_Mem_RValid, register the extended data and go to DONE. RValid in the same cycle as ready is ignored.
- Timeout:
  - Counter increments every cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT without progress → DONE with cause 11, o_LoadData=0.
  - Counter clears on entering REQ.
- DONE: o_Done=1 and o_Stall=0 for one cycle, then IDLE. i_Start is ignored in DONE and in any state other than IDLE.
- o_Stall = (IDLE & i_Start) | REQ | WAIT_R.
- o_LoadData holds its value until the next completion; it is zeroed on an error completion.
- Store steering:
  - SB: byte replicated to all four lanes, ByteEn = 1<<addr[1:0].
  - SH: halfword replicated to both halves, ByteEn = 0011 (addr[1]=0) or 1100.
  - SW: full word, ByteEn = 1111.
- Load extraction:
  - LB/LBU: lane addr[1:0], sign/zero extended.
  - LH/LHU: lane addr[1], sign/zero extended.
  - LW: full word.
- Loads drive ByteEn = 1111 and o_Mem_We=0.
- Address bits above ADDR_W+1 are ignored (wrap within the memory).
- Best-case latency: load done 3 cycles after the start cycle (ready and rvalid immediate); store done 2 cycles after.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Error-cause constants: ERR_MISALIGN=01, ERR_ILLEGAL=10, ERR_TIMEOUT=11.
  - FSM state encoding.
- One combinational sub-module, lsu_lane_align, does store steering, byte-enable generation and load extraction/extension. The top level holds the FSM, capture registers and the timeout counter.

Test Plan:
- SB, addr=0x0000_0006, wdata=0x0000_00A5, ready immediate → Mem_Addr=1, ByteEn=0100, WData=0xA5A5A5A5; o_Done 2 cycles after start, o_Error=0.
- LB, addr=0x0000_0007, RData=0x80112233 → o_LoadData=0xFFFFFF80. LBU at the same address → 0x00000080. Done 3 cycles after start.
- LH, addr=0x0000_0003 → o_Error=1, cause 01, o_Mem_Req never asserted, o_Done 1 cycle after start.
- LW with i_Mem_Ready held 0, TIMEOUT=15 → o_Stall high for 16 cycles (start cycle included), then o_Done=1, cause 11, o_LoadData=0.
- Store funct3=011, or MemRead=MemWrite=1 → cause 10, no memory request. A second i_Start during REQ is ignored (exactly one completion).
- Reset asserted while in WAIT_R → o_Mem_Req, o_Stall and o_Done immediately 0, state IDLE. The next LW (RData=0x12345678) completes normally with o_LoadData=0x12345678.
